// File: rtl/structure1_fc2layer.sv
// Second fully-connected layer: one MAC per cycle over the fc1 buffer, one neuron at a time.
// Optional macro STRUCTURE1_FC2_RELU_EN clamps negative neuron results to zero.
module structure1_fc2layer #(
  parameter int IN_LEN  = 128,
  parameter int OUT_LEN = 10,
  parameter int FRAC    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        fc2en,
  output logic [13:0] fc2dataaddr,
  input  logic [17:0] fc2datain,
  output logic [13:0] wt_addr,
  input  logic [17:0] wt_data,
  output logic        out_valid,
  output logic [17:0] out_data,
  output logic [3:0]  out_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  localparam logic [13:0] LAST_I  = 14'(IN_LEN - 1);
  localparam logic [13:0] IN_STEP = 14'(IN_LEN);
  localparam logic [3:0]  LAST_N  = 4'(OUT_LEN - 1);

  state_t             state_q, state_d;
  logic [13:0]        i_q, i_d;
  logic [13:0]        base_q, base_d;
  logic [3:0]         neuron_q, neuron_d;
  logic               accEn_q, accEn_d;
  logic signed [47:0] acc_q, acc_d;
  logic               outValid_q, outValid_d;
  logic [17:0]        outData_q, outData_d;
  logic [3:0]         outIdx_q, outIdx_d;
  logic               done_q, done_d;

  logic signed [17:0] dataS, wtS;
  logic signed [35:0] prod;
  logic signed [47:0] shifted;
  logic signed [17:0] satVal;
  logic signed [17:0] resultVal;

  assign dataS   = fc2datain;
  assign wtS     = wt_data;
  assign prod    = dataS * wtS;
  assign shifted = acc_q >>> FRAC;

  always_comb begin
    satVal = shifted[17:0];
    if (shifted > 48'sd131071) begin
      satVal = 18'sh1FFFF;
    end else if (shifted < -48'sd131072) begin
      satVal = 18'sh20000;
    end
  end

`ifdef STRUCTURE1_FC2_RELU_EN
  assign resultVal = satVal[17] ? 18'sd0 : satVal;
`else
  assign resultVal = satVal;
`endif

  // Read data arrives one cycle after its address, so accEn_q tracks the previous READ cycle.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    base_d      = base_q;
    neuron_d    = neuron_q;
    accEn_d     = (state_q == READ);
    acc_d       = accEn_q ? (acc_q + {{12{prod[35]}}, prod}) : acc_q;
    outValid_d  = 1'b0;
    outData_d   = outData_q;
    outIdx_d    = outIdx_q;
    done_d      = 1'b0;
    fc2en       = 1'b0;
    fc2dataaddr = 14'd0;
    wt_addr     = 14'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ;
          i_d      = 14'd0;
          base_d   = 14'd0;
          neuron_d = 4'd0;
          acc_d    = 48'sd0;
        end
      end
      READ: begin
        fc2en       = 1'b1;
        fc2dataaddr = i_q;
        wt_addr     = base_q + i_q;
        if (i_q == LAST_I) begin
          i_d     = 14'd0;
          state_d = DRAIN;
        end else begin
          i_d = i_q + 14'd1;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        outData_d  = resultVal;
        outIdx_d   = neuron_q;
        outValid_d = 1'b1;
        acc_d      = 48'sd0;
        if (neuron_q == LAST_N) begin
          done_d   = 1'b1;
          neuron_d = 4'd0;
          base_d   = 14'd0;
          state_d  = IDLE;
        end else begin
          neuron_d = neuron_q + 4'd1;
          base_d   = base_q + IN_STEP;
          state_d  = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      i_q        <= 14'd0;
      base_q     <= 14'd0;
      neuron_q   <= 4'd0;
      accEn_q    <= 1'b0;
      acc_q      <= 48'sd0;
      outValid_q <= 1'b0;
      outData_q  <= 18'd0;
      outIdx_q   <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      base_q     <= base_d;
      neuron_q   <= neuron_d;
      accEn_q    <= accEn_d;
      acc_q      <= acc_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outIdx_q   <= outIdx_d;
      done_q     <= done_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_idx   = outIdx_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/structure1_fc2layer.md
STRUCTURE1_FC2LAYER -- requirements
Module: structure1_fc2layer

Interface
REQ-001 SHALL have parameter IN_LEN, default 128, meaning number of fc1 outputs held in the fc1-to-fc2 buffer (2..1024).
REQ-002 SHALL have parameter OUT_LEN, default 10, meaning number of fc2 neurons (1..16).
REQ-003 SHALL have parameter FRAC, default 8, meaning fixed-point fraction bits of data and weights.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous reset, active-high (1 = reset) despite the name.
REQ-007 SHALL have port start, input, 1, one-cycle pulse from fc1 control once every fc1 result is written.
REQ-008 SHALL have port fc2en, output, 1, read enable to the fc1-to-fc2 buffer.
REQ-009 SHALL have port fc2dataaddr, output, 14, read address to the buffer.
REQ-010 SHALL have port fc2datain, input, 18, signed buffer read data, valid 1 cycle after its address.
REQ-011 SHALL have port wt_addr, output, 14, weight ROM address = neuron*IN_LEN + i.
REQ-012 SHALL have port wt_data, input, 18, signed weight, valid 1 cycle after wt_addr.
REQ-013 SHALL have port out_valid, output, 1, one-cycle strobe per neuron result.
REQ-014 SHALL have port out_data, output, 18, signed saturated neuron result.
REQ-015 SHALL have port out_idx, output, 4, neuron index of out_data.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse with the final out_valid.

Function
REQ-018 SHALL implement FSM IDLE, READ, DRAIN, OUT; IDLE->READ on start; READ->DRAIN after IN_LEN cycles; DRAIN->OUT; OUT->READ (neuron+1) or OUT->IDLE after neuron OUT_LEN-1.
REQ-019 SHALL in READ drive fc2en=1, fc2dataaddr=i, wt_addr=neuron*IN_LEN+i, i=0..IN_LEN-1, one per cycle; fc2en SHALL be 0 in every other state.
REQ-020 SHALL accumulate fc2datain*wt_data (18x18 signed -> 36 bit) into a 48-bit signed accumulator one cycle after each issued address; last product accumulated at end of DRAIN.
REQ-021 SHALL in OUT register out_data = saturate18(acc >>> FRAC) (arithmetic shift), clear acc, and assert out_valid with out_idx=neuron the following cycle.
REQ-022 SHALL saturate to +131071 / -131072 on overflow.
REQ-023 SHALL give latency: start sampled in cycle 0 -> first out_valid in cycle IN_LEN+3; subsequent out_valid every IN_LEN+2 cycles.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL accept a start arriving in the same cycle as done and begin a new pass.

Reset
REQ-026 SHALL on rst_n=1 force state IDLE, neuron=0, i=0, acc=0, fc2en=0, fc2dataaddr=0, wt_addr=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
REQ-027 SHALL on reset mid-pass abort immediately with no further out_valid or done from that pass.

Configuration
REQ-028 SHALL, with macro STRUCTURE1_FC2_RELU_EN defined, clamp negative results to 0 before out_data is registered; without it, pass signed saturated results unchanged.

Verification (IN_LEN=4, OUT_LEN=2, FRAC=8 unless stated)
REQ-029 SHALL check data all 256, weights all 256, start pulse -> out_data 1024 at cycles 7 and 13, out_idx 0 then 1, done at cycle 13.
REQ-030 SHALL check address sequence -> fc2dataaddr 0,1,2,3 twice; wt_addr 0..3 then 4..7; fc2en high exactly 8 cycles.
REQ-031 SHALL check data 131071, weights 131071 -> out_data 131071; weights -131072 -> out_data -131072 (no macro).
REQ-032 SHALL check data 256, weights -256 -> out_data -1024 without macro; 0 with STRUCTURE1_FC2_RELU_EN.
REQ-033 SHALL check reset asserted in cycle 3 of a pass -> all outputs reset values next cycle, no out_valid/done; fresh start then gives the REQ-029 result.
REQ-034 SHALL check start re-pulsed at cycle 4 -> ignored, exactly 2 out_valid and 1 done.
